parametrised_execute_unit: RTL and testbench

//  Execute-stage ALU for the 16-bit core family, generalised in data width.

---
 rtl/parametrised_execute_unit_pkg.sv | 64 ++++++
 rtl/parametrised_execute_unit_muldiv.sv | 115 +++++++++++
 rtl/parametrised_execute_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_parametrised_execute_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parametrised_execute_unit_pkg.sv
// -----------------------------------------------------------------------------
// parametrised_execute_unit_pkg
//
// Shared definitions for the execute-stage ALU:
//   - alu_op_e    : 5-bit opcode space presented on the 'op' port
//   - state_e     : control FSM states of the top level
//   - muldiv_op_e : operation select for the iterative multiply/divide engine
//   - helper functions that classify opcodes
// -----------------------------------------------------------------------------
package parametrised_execute_unit_pkg;

   // Opcode map. Any code not listed (including NOP) is treated as "no
   // operation": the result handshake still pulses, but nothing is written.
   typedef enum logic [4:0] {
      ALU_OP_NOP    = 5'd0,
      ALU_OP_ADD    = 5'd1,
      ALU_OP_SUB    = 5'd2,
      ALU_OP_AND    = 5'd3,
      ALU_OP_OR     = 5'd4,
      ALU_OP_NOT    = 5'd5,
      ALU_OP_PASS_A = 5'd6,
      ALU_OP_PASS_B = 5'd7,
      ALU_OP_SLLV   = 5'd8,
      ALU_OP_SLL_I  = 5'd9,
      ALU_OP_SRA_I  = 5'd10,
      ALU_OP_CMP    = 5'd11,
      ALU_OP_CMPI   = 5'd12,
      ALU_OP_SLTU   = 5'd13,
      ALU_OP_MUL    = 5'd14,
      ALU_OP_DIVU   = 5'd15,
      ALU_OP_REMU   = 5'd16
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      MD_MUL  = 2'd0,
      MD_DIVU = 2'd1,
      MD_REMU = 2'd2
   } muldiv_op_e;

   // Immediate shift count substituted for a zero count field in legacy mode.
   localparam logic [4:0] LEGACY_IMM_SHIFT = 5'd8;

   // True for the opcodes that run on the iterative engine.
   function automatic logic is_iter_op(input logic [4:0] op);
      return op inside {ALU_OP_MUL, ALU_OP_DIVU, ALU_OP_REMU};
   endfunction

   // Maps an iterative opcode onto the engine's operation select.
   function automatic muldiv_op_e to_muldiv_op(input logic [4:0] op);
      muldiv_op_e sel;
      case (op)
         ALU_OP_DIVU: sel = MD_DIVU;
         ALU_OP_REMU: sel = MD_REMU;
         default:     sel = MD_MUL;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/parametrised_execute_unit_muldiv.sv
// -----------------------------------------------------------------------------
// parametrised_execute_unit_muldiv
//
// Iterative engine for MUL (shift-add, low DATA_WIDTH bits) and DIVU/REMU
// (restoring division). One bit is processed per busy cycle; an operation
// takes exactly DATA_WIDTH busy cycles after the start edge.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high
//   start_i   in   load operands and begin (one-cycle pulse)
//   abort_i   in   abandon the operation in flight (wins over start_i)
//   op_i      in   operation select, sampled with start_i
//   a_i, b_i  in   operands, sampled with start_i
//   done_o    out  high during the final busy cycle
//   result_o  out  value after the current step; the final answer when done_o
//
// Register reuse:
//   work_q  : MUL accumulator / division partial remainder
//   shreg_q : MUL multiplier (shifts right) / dividend-quotient (shifts left)
//   opnd_q  : MUL multiplicand (shifts left) / divisor (static)
// -----------------------------------------------------------------------------
module parametrised_execute_unit_muldiv
   import parametrised_execute_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  muldiv_op_e            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic                  busy_q;
   logic [CNT_W-1:0]      cnt_q;
   muldiv_op_e            op_q;
   logic [DATA_WIDTH-1:0] work_q,  work_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] opnd_q,  opnd_d;
   logic [DATA_WIDTH:0]   rem_shift;

   // One iteration step.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      work_d    = work_q;
      shreg_d   = shreg_q;
      opnd_d    = opnd_q;
      rem_shift = '0;
      if (op_q == MD_MUL) begin
         if (shreg_q[0]) begin
            work_d = work_q + opnd_q;
         end
         opnd_d  = opnd_q << 1;
         shreg_d = shreg_q >> 1;
      end else begin
         // Bring the next dividend bit into the partial remainder and try to
         // subtract. A zero divisor always "fits", which yields an all-ones
         // quotient and leaves the dividend as the remainder.
         rem_shift = {work_q, shreg_q[DATA_WIDTH-1]};
         if (rem_shift >= {1'b0, opnd_q}) begin
            work_d  = DATA_WIDTH'(rem_shift - {1'b0, opnd_q});
            shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b1};
         end else begin
            work_d  = rem_shift[DATA_WIDTH-1:0];
            shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   assign done_o   = busy_q && (cnt_q == '0);
   assign result_o = (op_q == MD_DIVU) ? shreg_d : work_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state is written with <= so every flop samples pre-edge values.
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         op_q    <= MD_MUL;
         work_q  <= '0;
         shreg_q <= '0;
         opnd_q  <= '0;
      end else if (abort_i) begin
         busy_q <= 1'b0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= CNT_W'(DATA_WIDTH - 1);
         op_q   <= op_i;
         work_q <= '0;
         if (op_i == MD_MUL) begin
            shreg_q <= b_i;
            opnd_q  <= a_i;
         end else begin
            shreg_q <= a_i;
            opnd_q  <= b_i;
         end
      end else if (busy_q) begin
         work_q  <= work_d;
         shreg_q <= shreg_d;
         opnd_q  <= opnd_d;
         if (cnt_q == '0) begin
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/parametrised_execute_unit.sv
// -----------------------------------------------------------------------------
// parametrised_execute_unit
//
// Execute-stage ALU with valid/ready handshakes on both sides. Single-cycle
// ops (logic, add/sub, shifts, compares) produce a registered result one
// cycle after acceptance; MUL/DIVU/REMU run on the iterative engine and hold
// off new requests until their result is registered.
//
// Parameters:
//   DATA_WIDTH     operand/result width (>= 8, power of 2)
//   LEGACY_SHIFT   1: an immediate shift count of 0 means 8
//   ENABLE_MULDIV  0: iterative ops finish in one cycle with nothing written
//
// Ports:
//   clock, reset          clock / asynchronous active-high reset
//   flush                 synchronous abort; beats acceptance
//   in_valid, in_ready    request handshake
//   op                    opcode (alu_op_e)
//   operand_a, operand_b  operands (b carries the extended immediate)
//   shift_count           immediate shift count for SLL_I / SRA_I
//   out_valid, out_ready  result handshake
//   result                registered result
//   result_write_enable   result targets a GPR
//   t_value               T-flag value
//   t_write_enable        T-flag is written
// -----------------------------------------------------------------------------
module parametrised_execute_unit
   import parametrised_execute_unit_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter bit LEGACY_SHIFT  = 1'b1,
   parameter bit ENABLE_MULDIV = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [3:0]            shift_count,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_write_enable,
   output logic                  t_value,
   output logic                  t_write_enable
);

   localparam int SHW = $clog2(DATA_WIDTH);

   state_e                state_q, state_d;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] result_q,    result_d;
   logic                  rwe_q,       rwe_d;
   logic                  t_value_q,   t_value_d;
   logic                  twe_q,       twe_d;

   logic                  accept;
   logic                  start_iter;
   logic                  drain;
   logic                  md_done;
   logic [DATA_WIDTH-1:0] md_result;

   logic [4:0]            imm_cnt;
   logic [DATA_WIDTH-1:0] sra_res;
   logic [DATA_WIDTH-1:0] sc_result;
   logic                  sc_rwe;
   logic                  sc_t_value;
   logic                  sc_twe;

   // ---------------------------------------------------------------- handshake
   // A new request is only taken when the output register is free or is being
   // emptied this very cycle (accept-and-drain).
   assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready && !flush;
   assign start_iter = accept && ENABLE_MULDIV && is_iter_op(op);
   assign drain      = out_valid_q && out_ready;

   // ------------------------------------------------------ single-cycle path
   assign imm_cnt = (LEGACY_SHIFT && (shift_count == 4'd0)) ? LEGACY_IMM_SHIFT
                                                            : {1'b0, shift_count};
   assign sra_res = $signed(operand_b) >>> imm_cnt;

   always_comb begin
      sc_result  = '0;
      sc_rwe     = 1'b0;
      sc_t_value = 1'b0;
      sc_twe     = 1'b0;
      case (op)
         ALU_OP_ADD: begin
            sc_result = operand_a + operand_b;
            sc_rwe    = 1'b1;
         end
         ALU_OP_SUB: begin
            sc_result = operand_a - operand_b;
            sc_rwe    = 1'b1;
         end
         ALU_OP_AND: begin
            sc_result = operand_a & operand_b;
            sc_rwe    = 1'b1;
         end
         ALU_OP_OR: begin
            sc_result = operand_a | operand_b;
            sc_rwe    = 1'b1;
         end
         ALU_OP_NOT: begin
            sc_result = ~operand_b;
            sc_rwe    = 1'b1;
         end
         ALU_OP_PASS_A: begin
            sc_result = operand_a;
            sc_rwe    = 1'b1;
         end
         ALU_OP_PASS_B: begin
            sc_result = operand_b;
            sc_rwe    = 1'b1;
         end
         ALU_OP_SLLV: begin
            sc_result = operand_b << operand_a[SHW-1:0];
            sc_rwe    = 1'b1;
         end
         ALU_OP_SLL_I: begin
            sc_result = operand_b << imm_cnt;
            sc_rwe    = 1'b1;
         end
         ALU_OP_SRA_I: begin
            sc_result = sra_res;
            sc_rwe    = 1'b1;
         end
         ALU_OP_CMP, ALU_OP_CMPI: begin
            sc_t_value = (operand_a != operand_b);
            sc_twe     = 1'b1;
         end
         ALU_OP_SLTU: begin
            sc_t_value = (operand_a < operand_b);
            sc_twe     = 1'b1;
         end
         // NOP, unknown codes, and MUL/DIVU/REMU when the engine is absent.
         default: ;
      endcase
   end

   // --------------------------------------------------------- iterative path
   if (ENABLE_MULDIV) begin : g_muldiv
      parametrised_execute_unit_muldiv #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_muldiv (
         .clock    (clock),
         .reset    (reset),
         .start_i  (start_iter),
         .abort_i  (flush),
         .op_i     (to_muldiv_op(op)),
         .a_i      (operand_a),
         .b_i      (operand_b),
         .done_o   (md_done),
         .result_o (md_result)
      );
   end else begin : g_no_muldiv
      assign md_done   = 1'b0;
      assign md_result = '0;
   end

   // ------------------------------------------------------------- FSM: state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------- FSM: next state
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start_iter) state_d = ST_ITER;
            ST_ITER: if (md_done)    state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------- FSM: outputs
   // Output registers hold while a result waits for out_ready. The engine only
   // runs while out_valid is low, so its completion never collides with a
   // pending result.
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      rwe_d       = rwe_q;
      t_value_d   = t_value_q;
      twe_d       = twe_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if ((state_q == ST_ITER) && md_done) begin
         out_valid_d = 1'b1;
         result_d    = md_result;
         rwe_d       = 1'b1;
         t_value_d   = 1'b0;
         twe_d       = 1'b0;
      end else if (accept && !start_iter) begin
         out_valid_d = 1'b1;
         result_d    = sc_result;
         rwe_d       = sc_rwe;
         t_value_d   = sc_t_value;
         twe_d       = sc_twe;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         rwe_q       <= 1'b0;
         t_value_q   <= 1'b0;
         twe_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         rwe_q       <= rwe_d;
         t_value_q   <= t_value_d;
         twe_q       <= twe_d;
      end
   end

   assign out_valid           = out_valid_q;
   assign result              = result_q;
   assign result_write_enable = rwe_q;
   assign t_value             = t_value_q;
   assign t_write_enable      = twe_q;

endmodule

// File: tb/tb_parametrised_execute_unit.sv
// -----------------------------------------------------------------------------
// tb_parametrised_execute_unit
//
// Self-checking bench for parametrised_execute_unit at default parameters
// (DATA_WIDTH=16, LEGACY_SHIFT=1, ENABLE_MULDIV=1): a table of directed
// vectors, randomised transactions against an arithmetic reference model, and
// hand-written sequences for back-pressure, flush and reset corner cases.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_parametrised_execute_unit;
   import parametrised_execute_unit_pkg::*;

   localparam int W        = 16;
   localparam int ITER_LAT = W + 1;

   logic         clock = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   op;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic [3:0]   shift_count;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         result_write_enable;
   logic         t_value;
   logic         t_write_enable;

   int n_vec = 0;
   int n_err = 0;

   parametrised_execute_unit #(
      .DATA_WIDTH    (W),
      .LEGACY_SHIFT  (1'b1),
      .ENABLE_MULDIV (1'b1)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .flush               (flush),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .op                  (op),
      .operand_a           (operand_a),
      .operand_b           (operand_b),
      .shift_count         (shift_count),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .result              (result),
      .result_write_enable (result_write_enable),
      .t_value             (t_value),
      .t_write_enable      (t_write_enable)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] result;
      logic         rwe;
      logic         tv;
      logic         twe;
      int           lat;
   } exp_t;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   sc;
      logic [W-1:0] result;
      logic         rwe;
      logic         tv;
      logic         twe;
      int           lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the architectural rules.
   function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [3:0] sc);
      exp_t        e;
      int unsigned ua;
      int unsigned ub;
      int          sb;
      int          cnt;
      ua  = a;
      ub  = b;
      sb  = int'($signed(b));
      cnt = (sc == 4'd0) ? 8 : int'(sc);
      e.result = '0;
      e.rwe    = 1'b0;
      e.tv     = 1'b0;
      e.twe    = 1'b0;
      e.lat    = 1;
      case (o)
         ALU_OP_ADD:    begin e.result = W'((ua + ub) % 65536);     e.rwe = 1'b1; end
         ALU_OP_SUB:    begin e.result = W'((ua - ub) % 65536);     e.rwe = 1'b1; end
         ALU_OP_AND:    begin e.result = W'(ua & ub);               e.rwe = 1'b1; end
         ALU_OP_OR:     begin e.result = W'(ua | ub);               e.rwe = 1'b1; end
         ALU_OP_NOT:    begin e.result = W'(65535 - ub);            e.rwe = 1'b1; end
         ALU_OP_PASS_A: begin e.result = a;                         e.rwe = 1'b1; end
         ALU_OP_PASS_B: begin e.result = b;                         e.rwe = 1'b1; end
         ALU_OP_SLLV:   begin e.result = W'((ub << (ua % 16)) % 65536); e.rwe = 1'b1; end
         ALU_OP_SLL_I:  begin e.result = W'((ub << cnt) % 65536);   e.rwe = 1'b1; end
         ALU_OP_SRA_I:  begin e.result = W'(sb >>> cnt);            e.rwe = 1'b1; end
         ALU_OP_CMP,
         ALU_OP_CMPI:   begin e.tv = (ua != ub); e.twe = 1'b1; end
         ALU_OP_SLTU:   begin e.tv = (ua < ub);  e.twe = 1'b1; end
         ALU_OP_MUL: begin
            e.result = W'((ua * ub) % 65536);
            e.rwe = 1'b1; e.lat = ITER_LAT;
         end
         ALU_OP_DIVU: begin
            e.result = (ub == 0) ? W'(65535) : W'(ua / ub);
            e.rwe = 1'b1; e.lat = ITER_LAT;
         end
         ALU_OP_REMU: begin
            e.result = (ub == 0) ? a : W'(ua % ub);
            e.rwe = 1'b1; e.lat = ITER_LAT;
         end
         default: ;
      endcase
      return e;
   endfunction

   // Issues one request with out_ready=1, waits (bounded) for the result,
   // compares it, then lets it drain. Entered and left at posedge+1.
   task automatic run_and_compare(input string tag, input logic [4:0] o,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] sc, input exp_t e);
      int guard;
      int lat;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clock); #1;
         guard++;
      end
      check({tag, ".in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1; op = o; operand_a = a; operand_b = b; shift_count = sc;
      out_ready = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      if (!out_valid) begin
         check({tag, ".out_valid_timeout"}, out_valid, 1'b1);
      end else begin
         check({tag, ".result"}, result, e.result);
         check({tag, ".rwe"},    result_write_enable, e.rwe);
         check({tag, ".t_value"}, t_value, e.tv);
         check({tag, ".twe"},    t_write_enable, e.twe);
         check({tag, ".latency"}, lat, e.lat);
      end
      @(posedge clock); #1;
   endtask

   // Watches for any out_valid over a window; a partial result would show here.
   task automatic expect_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (out_valid) seen++;
         @(posedge clock); #1;
      end
      check({tag, ".no_out_valid"}, seen, 0);
   endtask

   task automatic start_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1; op = o; operand_a = a; operand_b = b; shift_count = 4'd0;
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   vec_t vecs[$];
   exp_t e;

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0;
      operand_a = '0; operand_b = '0; shift_count = '0; out_ready = 1'b1;

      // ---------------------------------------------------------- reset state
      repeat (2) @(posedge clock);
      #1;
      check("reset.out_valid", out_valid, 1'b0);
      check("reset.result",    result,    '0);
      check("reset.rwe",       result_write_enable, 1'b0);
      check("reset.t_value",   t_value,   1'b0);
      check("reset.twe",       t_write_enable, 1'b0);
      check("reset.in_ready",  in_ready,  1'b1);
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;

      // ------------------------------------------------------ directed table
      vecs.push_back('{ALU_OP_ADD,    16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_SUB,    16'h0000, 16'h0001, 4'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_AND,    16'hF0F0, 16'h3C3C, 4'd0, 16'h3030, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_OR,     16'hF0F0, 16'h0F01, 4'd0, 16'hFFF1, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_NOT,    16'h1234, 16'h00FF, 4'd0, 16'hFF00, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_PASS_A, 16'h1234, 16'hABCD, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_PASS_B, 16'h1234, 16'hABCD, 4'd0, 16'hABCD, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_SLLV,   16'h0013, 16'h0001, 4'd0, 16'h0008, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_SLL_I,  16'h0000, 16'h0001, 4'd0, 16'h0100, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_SLL_I,  16'h0000, 16'h0001, 4'd4, 16'h0010, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_SRA_I,  16'h0000, 16'h8000, 4'd0, 16'hFF80, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_SRA_I,  16'h0000, 16'h4000, 4'd2, 16'h1000, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ALU_OP_CMP,    16'd5,    16'd5,    4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1});
      vecs.push_back('{ALU_OP_CMP,    16'd5,    16'd6,    4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1});
      vecs.push_back('{ALU_OP_CMPI,   16'd7,    16'd7,    4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1});
      vecs.push_back('{ALU_OP_SLTU,   16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1});
      vecs.push_back('{ALU_OP_SLTU,   16'h0001, 16'hFFFF, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1});
      vecs.push_back('{ALU_OP_MUL,    16'd300,  16'd300,  4'd0, 16'h5F90, 1'b1, 1'b0, 1'b0, 17});
      vecs.push_back('{ALU_OP_MUL,    16'hFFFF, 16'hFFFF, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0, 17});
      vecs.push_back('{ALU_OP_DIVU,   16'd100,  16'd0,    4'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 17});
      vecs.push_back('{ALU_OP_DIVU,   16'd100,  16'd7,    4'd0, 16'h000E, 1'b1, 1'b0, 1'b0, 17});
      vecs.push_back('{ALU_OP_DIVU,   16'hFFFF, 16'hFFFF, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0, 17});
      vecs.push_back('{ALU_OP_REMU,   16'd100,  16'd7,    4'd0, 16'h0002, 1'b1, 1'b0, 1'b0, 17});
      vecs.push_back('{ALU_OP_REMU,   16'd100,  16'd0,    4'd0, 16'h0064, 1'b1, 1'b0, 1'b0, 17});
      vecs.push_back('{ALU_OP_NOP,    16'h1111, 16'h2222, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{5'd31,         16'h1111, 16'h2222, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1});

      for (int i = 0; i < vecs.size(); i++) begin
         e.result = vecs[i].result;
         e.rwe    = vecs[i].rwe;
         e.tv     = vecs[i].tv;
         e.twe    = vecs[i].twe;
         e.lat    = vecs[i].lat;
         run_and_compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                         vecs[i].sc, e);
      end

      // ------------------------------------------- MUL: in_ready low 16 cycles
      in_valid = 1'b1; op = ALU_OP_MUL; operand_a = 16'd300; operand_b = 16'd300;
      out_ready = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      begin
         int busy_cycles;
         busy_cycles = 0;
         for (int i = 0; i < 16; i++) begin
            if (!in_ready && !out_valid) busy_cycles++;
            @(posedge clock); #1;
         end
         check("mul.busy_cycles", busy_cycles, 16);
      end
      check("mul.cycle17_out_valid", out_valid, 1'b1);
      check("mul.cycle17_result",    result,    16'h5F90);
      @(posedge clock); #1;

      // ------------------------- back-pressure, then accept-and-drain together
      out_ready = 1'b0;
      start_op(ALU_OP_ADD, 16'd3, 16'd4);
      in_valid = 1'b1; op = ALU_OP_SUB; operand_a = 16'd10; operand_b = 16'd1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall%0d.out_valid", i), out_valid, 1'b1);
         check($sformatf("stall%0d.result", i),    result,    16'd7);
         check($sformatf("stall%0d.in_ready", i),  in_ready,  1'b0);
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      #1;
      check("drain.in_ready", in_ready, 1'b1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      check("drain.next_out_valid", out_valid, 1'b1);
      check("drain.next_result",    result,    16'd9);
      @(posedge clock); #1;
      check("drain.empty", out_valid, 1'b0);

      // ---------------------------------------------------- flush mid-DIVU
      start_op(ALU_OP_DIVU, 16'd100, 16'd7);
      repeat (5) @(posedge clock);
      #1;
      check("flush.busy", in_ready, 1'b0);
      flush = 1'b1; in_valid = 1'b1; op = ALU_OP_ADD; operand_a = 16'd1; operand_b = 16'd1;
      @(posedge clock); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush.out_valid", out_valid, 1'b0);
      check("flush.in_ready",  in_ready,  1'b1);
      expect_quiet("flush", 20);
      e = model(ALU_OP_ADD, 16'd2, 16'd3, 4'd0);
      run_and_compare("after_flush", ALU_OP_ADD, 16'd2, 16'd3, 4'd0, e);

      // ----------------------------------------- flush beats accept in IDLE
      flush = 1'b1; in_valid = 1'b1; op = ALU_OP_ADD; operand_a = 16'd5; operand_b = 16'd5;
      @(posedge clock); #1;
      flush = 1'b0; in_valid = 1'b0;
      expect_quiet("flush_idle", 3);

      // ------------------------------------ flush clears a held result
      out_ready = 1'b0;
      start_op(ALU_OP_ADD, 16'd1, 16'd2);
      check("hold.out_valid", out_valid, 1'b1);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check("flush_hold.out_valid", out_valid, 1'b0);
      out_ready = 1'b1;

      // ---------------------------------------------------- reset mid-DIVU
      start_op(ALU_OP_DIVU, 16'd1000, 16'd3);
      repeat (8) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("rst_iter.out_valid", out_valid, 1'b0);
      check("rst_iter.in_ready",  in_ready,  1'b1);
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      expect_quiet("rst_iter", 20);
      e = model(ALU_OP_ADD, 16'h1234, 16'h1111, 4'd0);
      run_and_compare("after_reset", ALU_OP_ADD, 16'h1234, 16'h1111, 4'd0, e);

      // ------------------------------------------------------------ random
      for (int i = 0; i < 200; i++) begin
         logic [4:0]   ro;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic [3:0]   rs;
         ro = 5'($urandom_range(0, 31));
         ra = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = W'($urandom_range(1, 15));
            default: rb = W'($urandom);
         endcase
         rs = 4'($urandom);
         e  = model(ro, ra, rb, rs);
         run_and_compare($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, rs, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
